usbfs_ctrl_xfer_seq: RTL and testbench
======================================

# usbfs_ctrl_xfer_seq

Synthesizable control-transfer sequencer on the host side of the USB full-speed path. It sits directly upstream of the host transactor and consumes the same `txn*`/`et0*` handshake the transactor exposes. A whole control transfer (8-byte setup payload plus device address) is accepted as one request and expanded into SETUP, IN data-stage and status-stage transactions on endpoint 0. It reports one completion per request.

## Interface
Parameters:
- `MAX_PKT`, 8: endpoint-0 max packet size in bytes.
- `MAX_RETRY`, 3: consecutive TIMEOUT results tolerated per transaction before ERROR.

Ports:
- `i_clk`  in  1  sole clock.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_reqValid`  in  1  transfer request valid.
- `o_reqReady`  out  1  request accepted when both high.
- `i_reqAddr`  in  7  device address.
- `i_reqSetup`  in  64  setup payload; `[7]` direction, `[63:48]` wLength.
- `i_txnReady`  in  1  transactor ready.
- `o_txnValid`  out  1  transaction request valid.
- `o_txnType`  out  3  one-hot {SETUP,OUT,IN} = 100/010/001.
- `o_txnAddr`  out  7  target address.
- `o_txnEndp`  out  4  always 0.
- `o_et0Data`  out  8*MAX_PKT  SETUP payload.
- `o_et0Data_nBytes`  out  $clog2(MAX_PKT)+1  8 for SETUP, 0 otherwise.
- `i_rsltValid`  in  1  transaction result strobe (one cycle).
- `i_rsltCode`  in  2  0 ACK, 1 NAK, 2 STALL, 3 TIMEOUT.
- `i_rsltNBytes`  in  $clog2(MAX_PKT)+1  IN payload length on ACK.
- `o_cplValid`  out  1  completion valid.
- `i_cplReady`  in  1  completion accepted when both high.
- `o_cplStatus`  out  2  0 OK, 1 STALL, 2 ERROR, 3 UNSUPPORTED.
- `o_cplNBytes`  out  16  data-stage bytes received.

## Operation
- States: IDLE, SETUP_ISS, SETUP_WAIT, DATA_ISS, DATA_WAIT, STAT_ISS, STAT_WAIT, CPL.
- IDLE: `o_reqReady`=1. On accept, latch addr/setup, clear byte count and retry count.
  - If direction=0 and wLength≠0, go to CPL with UNSUPPORTED.
  - Otherwise go to SETUP_ISS.
- *_ISS states: `o_txnValid`=1 with fixed type/addr/data. On `i_txnReady`, go to the matching *_WAIT state.
- Result handling in *_WAIT states:
  - ACK advances.
  - NAK reissues the same transaction, with no retry-count change.
  - TIMEOUT increments the retry count and reissues. When the count reaches MAX_RETRY, go to CPL with ERROR.
  - STALL goes to CPL with STALL and no status stage.
  - Any ACK clears the retry count.
  - In SETUP_WAIT, NAK is treated as TIMEOUT.
- SETUP ACK: go to DATA_ISS if wLength≠0, else STAT_ISS.
- Data stage (type IN):
  - Each ACK adds `i_rsltNBytes` to a 17-bit count.
  - The stage ends when `i_rsltNBytes`<MAX_PKT (short packet, including zero-length) or count≥wLength.
- Status stage:
  - OUT with nBytes=0 after an IN data stage.
  - IN after a no-data transfer.
  - ACK goes to CPL with OK.
- CPL: `o_cplValid`=1. `o_cplNBytes`=min(count,16'hffff). On `i_cplReady`, go to IDLE.

## Timing
- Reset values:
  - Outputs: `o_reqReady`=0 while `i_rstn` low, then 1; `o_txnValid`=0, `o_cplValid`=0, `o_txnType`=0, `o_txnAddr`=0, `o_et0Data`=0, `o_et0Data_nBytes`=0, `o_cplStatus`=0, `o_cplNBytes`=0.
  - Internal state: IDLE.
- All outputs are registered. Request accepted at edge N → `o_txnValid` high from N+1.
- `o_txnValid` and its payload stay stable until accepted. They drop the cycle after acceptance.
- Result arrives ≥1 cycle after acceptance. The result sampled in *_WAIT at edge M → next ISS or CPL from M+1.
- `i_rsltValid` outside *_WAIT states is ignored.
- `o_cplValid` and its fields stay stable until accepted. The next request can be accepted at the edge after completion acceptance at the earliest.
- Reset mid-transfer aborts immediately: no completion, no further transactions.
- Count boundary: wLength=0xffff with repeated full packets saturates the reported count at 0xffff. The 17-bit internal count never wraps.

## Test plan
- GET_DESCRIPTOR DEVICE (setup 0x0012_0000_0100_0680, addr 0); transactor ACKs IN with 8,8,2 → SETUP, IN×3, OUT nBytes=0; completion OK, nBytes=18.
- SET_ADDRESS (setup 0x0000_0000_0037_0500) → SETUP then status IN, no data stage; completion OK, nBytes=0.
- GET_DESCRIPTOR CONFIG wLength 0xffff; INs return 8,8,8,8,0 → five INs then OUT status; completion OK, nBytes=32.
- STRING descriptor; first data IN returns STALL → no status transaction; completion STALL, nBytes=0.
- First data IN gets NAK×5 then ACK 8; a later IN gets TIMEOUT×3 → six attempts on the first IN; completion ERROR on the third timeout.
- Host-to-device request with wLength=4 → zero transactions; completion UNSUPPORTED. Separately, `i_rstn` low during DATA_WAIT → `o_txnValid` and `o_cplValid` low; next request starts cleanly from SETUP.

Source files
------------

// File: rtl/usbfs_ctrl_xfer_seq.sv
// Host-side USB full-speed control-transfer sequencer: expands one request into
// SETUP / IN data / status transactions on endpoint 0 and reports one completion.
module usbfs_ctrl_xfer_seq #(
   parameter int unsigned MAX_PKT   = 8,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic                          i_reqValid,
   output logic                          o_reqReady,
   input  logic [6:0]                    i_reqAddr,
   input  logic [63:0]                   i_reqSetup,
   input  logic                          i_txnReady,
   output logic                          o_txnValid,
   output logic [2:0]                    o_txnType,
   output logic [6:0]                    o_txnAddr,
   output logic [3:0]                    o_txnEndp,
   output logic [8*MAX_PKT-1:0]          o_et0Data,
   output logic [$clog2(MAX_PKT):0]      o_et0Data_nBytes,
   input  logic                          i_rsltValid,
   input  logic [1:0]                    i_rsltCode,
   input  logic [$clog2(MAX_PKT):0]      i_rsltNBytes,
   output logic                          o_cplValid,
   input  logic                          i_cplReady,
   output logic [1:0]                    o_cplStatus,
   output logic [15:0]                   o_cplNBytes
);

   localparam int unsigned NBW = $clog2(MAX_PKT) + 1;
   localparam int unsigned RW  = $clog2(MAX_RETRY + 1);
   localparam logic [NBW-1:0] PKT_FULL  = NBW'(MAX_PKT);
   localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP_ISS, S_SETUP_WAIT, S_DATA_ISS,
      S_DATA_WAIT, S_STAT_ISS, S_STAT_WAIT, S_CPL
   } state_e;

   typedef enum logic [2:0] {
      TT_NONE = 3'b000, TT_IN = 3'b001, TT_OUT = 3'b010, TT_SETUP = 3'b100
   } txn_type_e;

   typedef enum logic [1:0] {
      R_ACK = 2'd0, R_NAK = 2'd1, R_STALL = 2'd2, R_TIMEOUT = 2'd3
   } rslt_e;

   typedef enum logic [1:0] {
      C_OK = 2'd0, C_STALL = 2'd1, C_ERROR = 2'd2, C_UNSUP = 2'd3
   } cpl_e;

   state_e                state_q, state_d, reissue;
   logic                  req_ready_q, req_ready_d;
   logic                  txn_valid_q, txn_valid_d;
   txn_type_e             txn_type_q, txn_type_d;
   logic [6:0]            txn_addr_q, txn_addr_d;
   logic [8*MAX_PKT-1:0]  et0_data_q, et0_data_d;
   logic [NBW-1:0]        et0_nbytes_q, et0_nbytes_d;
   logic                  cpl_valid_q, cpl_valid_d;
   cpl_e                  cpl_status_q, cpl_status_d;
   logic [15:0]           cpl_nbytes_q, cpl_nbytes_d;
   logic [6:0]            addr_q, addr_d;
   logic [63:0]           setup_q, setup_d;
   logic [16:0]           count_q, count_d;
   logic [RW-1:0]         retry_q, retry_d;

   rslt_e                 rslt;
   logic [15:0]           wlen;
   logic [17:0]           sum;
   logic [16:0]           count_acc;
   logic                  data_done;
   logic                  is_tmo;
   logic [RW-1:0]         retry_inc;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      setup_d      = setup_q;
      count_d      = count_q;
      retry_d      = retry_q;
      cpl_status_d = cpl_status_q;
      cpl_nbytes_d = cpl_nbytes_q;
      txn_type_d   = txn_type_q;
      txn_addr_d   = txn_addr_q;
      et0_data_d   = et0_data_q;
      et0_nbytes_d = et0_nbytes_q;

      rslt      = rslt_e'(i_rsltCode);
      wlen      = setup_q[63:48];
      sum       = {1'b0, count_q} + 18'(i_rsltNBytes);
      count_acc = sum[17] ? '1 : sum[16:0];
      data_done = (i_rsltNBytes < PKT_FULL) || (count_acc >= {1'b0, wlen});
      // SETUP may not be NAKed by a device, so a NAK there counts as a failed attempt
      is_tmo    = (rslt == R_TIMEOUT) || ((rslt == R_NAK) && (state_q == S_SETUP_WAIT));
      retry_inc = retry_q + RW'(1);

      case (state_q)
         S_SETUP_WAIT: reissue = S_SETUP_ISS;
         S_DATA_WAIT:  reissue = S_DATA_ISS;
         default:      reissue = S_STAT_ISS;
      endcase

      case (state_q)
         S_IDLE: begin
            if (i_reqValid && req_ready_q) begin
               addr_d  = i_reqAddr;
               setup_d = i_reqSetup;
               count_d = '0;
               retry_d = '0;
               if (!i_reqSetup[7] && (i_reqSetup[63:48] != '0)) begin
                  state_d      = S_CPL;
                  cpl_status_d = C_UNSUP;
               end else begin
                  state_d = S_SETUP_ISS;
               end
            end
         end
         S_SETUP_ISS: if (i_txnReady) state_d = S_SETUP_WAIT;
         S_DATA_ISS:  if (i_txnReady) state_d = S_DATA_WAIT;
         S_STAT_ISS:  if (i_txnReady) state_d = S_STAT_WAIT;
         S_SETUP_WAIT, S_DATA_WAIT, S_STAT_WAIT: begin
            if (i_rsltValid) begin
               if (rslt == R_STALL) begin
                  state_d      = S_CPL;
                  cpl_status_d = C_STALL;
               end else if (rslt == R_ACK) begin
                  retry_d = '0;
                  case (state_q)
                     S_SETUP_WAIT: state_d = (wlen != '0) ? S_DATA_ISS : S_STAT_ISS;
                     S_DATA_WAIT: begin
                        count_d = count_acc;
                        state_d = data_done ? S_STAT_ISS : S_DATA_ISS;
                     end
                     default: begin
                        state_d      = S_CPL;
                        cpl_status_d = C_OK;
                     end
                  endcase
               end else if (is_tmo) begin
                  if (retry_inc == RETRY_LIM) begin
                     state_d      = S_CPL;
                     cpl_status_d = C_ERROR;
                  end else begin
                     retry_d = retry_inc;
                     state_d = reissue;
                  end
               end else begin
                  state_d = reissue;
               end
            end
         end
         S_CPL: if (i_cplReady) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it
      req_ready_d = (state_d == S_IDLE);
      txn_valid_d = (state_d == S_SETUP_ISS) || (state_d == S_DATA_ISS) || (state_d == S_STAT_ISS);
      cpl_valid_d = (state_d == S_CPL);

      if (txn_valid_d) begin
         txn_addr_d   = addr_d;
         et0_data_d   = '0;
         et0_nbytes_d = '0;
         if (state_d == S_SETUP_ISS) begin
            txn_type_d        = TT_SETUP;
            et0_data_d[63:0]  = setup_d;
            et0_nbytes_d      = NBW'(8);
         end else if (state_d == S_DATA_ISS) begin
            txn_type_d = TT_IN;
         end else begin
            txn_type_d = (setup_d[63:48] != '0) ? TT_OUT : TT_IN;
         end
      end

      if (cpl_valid_d && (state_q != S_CPL))
         cpl_nbytes_d = count_d[16] ? 16'hffff : count_d[15:0];
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b0;
         txn_valid_q  <= 1'b0;
         txn_type_q   <= TT_NONE;
         txn_addr_q   <= '0;
         et0_data_q   <= '0;
         et0_nbytes_q <= '0;
         cpl_valid_q  <= 1'b0;
         cpl_status_q <= C_OK;
         cpl_nbytes_q <= '0;
         addr_q       <= '0;
         setup_q      <= '0;
         count_q      <= '0;
         retry_q      <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         txn_valid_q  <= txn_valid_d;
         txn_type_q   <= txn_type_d;
         txn_addr_q   <= txn_addr_d;
         et0_data_q   <= et0_data_d;
         et0_nbytes_q <= et0_nbytes_d;
         cpl_valid_q  <= cpl_valid_d;
         cpl_status_q <= cpl_status_d;
         cpl_nbytes_q <= cpl_nbytes_d;
         addr_q       <= addr_d;
         setup_q      <= setup_d;
         count_q      <= count_d;
         retry_q      <= retry_d;
      end
   end

   assign o_reqReady       = req_ready_q;
   assign o_txnValid       = txn_valid_q;
   assign o_txnType        = txn_type_q;
   assign o_txnAddr        = txn_addr_q;
   assign o_txnEndp        = '0;
   assign o_et0Data        = et0_data_q;
   assign o_et0Data_nBytes = et0_nbytes_q;
   assign o_cplValid       = cpl_valid_q;
   assign o_cplStatus      = cpl_status_q;
   assign o_cplNBytes      = cpl_nbytes_q;

endmodule

// File: tb/tb_usbfs_ctrl_xfer_seq.sv
// Scoreboard bench for usbfs_ctrl_xfer_seq: a transactor model answers scripted
// results, a monitor checks every transaction and completion against queued expectations.
module tb_usbfs_ctrl_xfer_seq;

   localparam logic [2:0] T_SETUP = 3'b100;
   localparam logic [2:0] T_OUT   = 3'b010;
   localparam logic [2:0] T_IN    = 3'b001;
   localparam logic [1:0] ACK = 2'd0, NAK = 2'd1, STL = 2'd2, TMO = 2'd3;
   localparam logic [1:0] C_OK = 2'd0, C_STALL = 2'd1, C_ERR = 2'd2, C_UNSUP = 2'd3;
   localparam logic [63:0] SU_DEV  = 64'h0012_0000_0100_0680;
   localparam logic [63:0] SU_ADDR = 64'h0000_0000_0037_0500;
   localparam logic [63:0] SU_CFG  = 64'hFFFF_0000_0200_0680;
   localparam logic [63:0] SU_STR  = 64'h00FF_0409_0302_0680;
   localparam logic [63:0] SU_H2D  = 64'h0004_0000_0000_0321;

   logic        i_clk, i_rstn;
   logic        i_reqValid, o_reqReady;
   logic [6:0]  i_reqAddr;
   logic [63:0] i_reqSetup;
   logic        i_txnReady, o_txnValid;
   logic [2:0]  o_txnType;
   logic [6:0]  o_txnAddr;
   logic [3:0]  o_txnEndp;
   logic [63:0] o_et0Data;
   logic [3:0]  o_et0Data_nBytes;
   logic        i_rsltValid;
   logic [1:0]  i_rsltCode;
   logic [3:0]  i_rsltNBytes;
   logic        o_cplValid, i_cplReady;
   logic [1:0]  o_cplStatus;
   logic [15:0] o_cplNBytes;

   typedef struct { logic [2:0] ttype; logic [6:0] addr; logic [63:0] data; logic [3:0] nb; } txn_t;
   typedef struct { logic [1:0] code; logic [3:0] nb; bit hang; } rslt_t;
   typedef struct { logic [1:0] st; logic [15:0] nb; } cpl_t;

   txn_t  exp_txn[$];
   rslt_t rsp_q[$];
   cpl_t  exp_cpl[$];
   txn_t  mon_t;
   cpl_t  mon_c;
   rslt_t rsp_r;
   bit    rsp_pend;

   int unsigned pass_cnt = 0, total_cnt = 0;
   int unsigned txn_seen = 0, cpl_seen = 0, ncpl = 0;
   int unsigned spur_cnt = 0, spur_done = 0;

   usbfs_ctrl_xfer_seq #(.MAX_PKT(8), .MAX_RETRY(3)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
      .i_reqAddr(i_reqAddr), .i_reqSetup(i_reqSetup),
      .i_txnReady(i_txnReady), .o_txnValid(o_txnValid),
      .o_txnType(o_txnType), .o_txnAddr(o_txnAddr), .o_txnEndp(o_txnEndp),
      .o_et0Data(o_et0Data), .o_et0Data_nBytes(o_et0Data_nBytes),
      .i_rsltValid(i_rsltValid), .i_rsltCode(i_rsltCode), .i_rsltNBytes(i_rsltNBytes),
      .o_cplValid(o_cplValid), .i_cplReady(i_cplReady),
      .o_cplStatus(o_cplStatus), .o_cplNBytes(o_cplNBytes)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
   endtask

   task automatic setup_txn(input logic [6:0] a, input logic [63:0] s, input logic [1:0] code);
      exp_txn.push_back('{T_SETUP, a, s, 4'd8});
      rsp_q.push_back('{code, 4'd0, 1'b0});
   endtask

   task automatic io_txn(input logic [2:0] t, input logic [6:0] a, input logic [1:0] code,
                         input logic [3:0] nb, input bit hang);
      exp_txn.push_back('{t, a, 64'h0, 4'd0});
      rsp_q.push_back('{code, nb, hang});
   endtask

   task automatic expect_cpl(input logic [1:0] st, input logic [15:0] nb);
      exp_cpl.push_back('{st, nb});
      ncpl++;
   endtask

   task automatic send_req(input logic [6:0] a, input logic [63:0] s);
      int unsigned n = 0;
      i_reqAddr  = a;
      i_reqSetup = s;
      i_reqValid = 1'b1;
      while (!o_reqReady && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_reqReady) check("req_accept_timeout", 0, 1);
      @(negedge i_clk);
      i_reqValid = 1'b0;
   endtask

   task automatic wait_cpl(input int unsigned limit);
      int unsigned n = 0;
      while (cpl_seen < ncpl && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check("cpl_arrived", cpl_seen, ncpl);
   endtask

   // Transactor model: answers each accepted transaction one cycle later
   initial begin
      rsp_pend = 1'b0;
      forever begin
         @(negedge i_clk);
         #2;
         i_rsltValid = 1'b0;
         if (!i_rstn) begin
            rsp_pend = 1'b0;
         end else if (rsp_pend) begin
            rsp_pend = 1'b0;
            if (rsp_q.size() == 0) begin
               check("rslt_available", 0, 1);
            end else begin
               rsp_r = rsp_q.pop_front();
               if (!rsp_r.hang) begin
                  i_rsltValid  = 1'b1;
                  i_rsltCode   = rsp_r.code;
                  i_rsltNBytes = rsp_r.nb;
               end
            end
         end else if (spur_done != spur_cnt) begin
            spur_done    = spur_cnt;
            i_rsltValid  = 1'b1;
            i_rsltCode   = STL;
            i_rsltNBytes = 4'd0;
         end else if (o_txnValid && i_txnReady) begin
            rsp_pend = 1'b1;
         end
      end
   end

   // Monitor: compare every handshake against the scoreboard queues
   initial begin
      forever begin
         @(negedge i_clk);
         #2;
         if (i_rstn && o_txnValid && i_txnReady) begin
            txn_seen++;
            if (exp_txn.size() == 0) begin
               check("txn_unexpected", {o_txnType, o_txnAddr}, 0);
            end else begin
               mon_t = exp_txn.pop_front();
               check("txn_fields",
                     {o_txnType, o_txnAddr, o_txnEndp, o_et0Data_nBytes,
                      (mon_t.ttype == T_SETUP) ? o_et0Data : 64'h0},
                     {mon_t.ttype, mon_t.addr, 4'h0, mon_t.nb,
                      (mon_t.ttype == T_SETUP) ? mon_t.data : 64'h0});
            end
         end
         if (i_rstn && o_cplValid && i_cplReady) begin
            cpl_seen++;
            if (exp_cpl.size() == 0) begin
               check("cpl_unexpected", {o_cplStatus, o_cplNBytes}, 0);
            end else begin
               mon_c = exp_cpl.pop_front();
               check("cpl_fields", {o_cplStatus, o_cplNBytes}, {mon_c.st, mon_c.nb});
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      int unsigned n;
      i_rstn = 1'b0; i_reqValid = 1'b0; i_reqAddr = '0; i_reqSetup = '0;
      i_txnReady = 1'b1; i_cplReady = 1'b1;
      i_rsltValid = 1'b0; i_rsltCode = '0; i_rsltNBytes = '0;
      repeat (3) @(negedge i_clk);
      check("reset_outputs",
            {o_reqReady, o_txnValid, o_cplValid, o_txnType, o_txnAddr, o_et0Data_nBytes,
             o_cplStatus, o_cplNBytes, o_et0Data}, 0);
      i_rstn = 1'b1;
      @(negedge i_clk);
      check("ready_after_reset", o_reqReady, 1);

      // GET_DESCRIPTOR device, completion held off by i_cplReady
      setup_txn(7'h00, SU_DEV, ACK);
      io_txn(T_IN, 7'h00, ACK, 4'd8, 0);
      io_txn(T_IN, 7'h00, ACK, 4'd8, 0);
      io_txn(T_IN, 7'h00, ACK, 4'd2, 0);
      io_txn(T_OUT, 7'h00, ACK, 4'd0, 0);
      expect_cpl(C_OK, 16'd18);
      i_cplReady = 1'b0;
      send_req(7'h00, SU_DEV);
      n = 0;
      while (!o_cplValid && n < 200) begin @(negedge i_clk); n++; end
      repeat (2) @(negedge i_clk);
      check("cpl_hold", {o_cplValid, o_cplStatus, o_cplNBytes}, {1'b1, C_OK, 16'd18});
      i_cplReady = 1'b1;
      wait_cpl(200);

      // stray result strobe while idle, then SET_ADDRESS with transactor backpressure
      spur_cnt++;
      repeat (3) @(negedge i_clk);
      setup_txn(7'h12, SU_ADDR, ACK);
      io_txn(T_IN, 7'h12, ACK, 4'd0, 0);
      expect_cpl(C_OK, 16'd0);
      i_txnReady = 1'b0;
      send_req(7'h12, SU_ADDR);
      repeat (2) @(negedge i_clk);
      check("txn_hold", {o_txnValid, o_txnType, o_et0Data_nBytes, o_txnAddr},
            {1'b1, T_SETUP, 4'd8, 7'h12});
      i_txnReady = 1'b1;
      wait_cpl(200);

      // GET_DESCRIPTOR config, wLength 0xffff ended by zero-length packet
      setup_txn(7'h05, SU_CFG, ACK);
      for (int i = 0; i < 4; i++) io_txn(T_IN, 7'h05, ACK, 4'd8, 0);
      io_txn(T_IN, 7'h05, ACK, 4'd0, 0);
      io_txn(T_OUT, 7'h05, ACK, 4'd0, 0);
      expect_cpl(C_OK, 16'd32);
      send_req(7'h05, SU_CFG);
      wait_cpl(300);

      // string descriptor stalled in the data stage
      setup_txn(7'h05, SU_STR, ACK);
      io_txn(T_IN, 7'h05, STL, 4'd0, 0);
      expect_cpl(C_STALL, 16'd0);
      send_req(7'h05, SU_STR);
      wait_cpl(200);

      // NAK x5 then ACK 8, then three timeouts on the next IN
      setup_txn(7'h03, SU_DEV, ACK);
      for (int i = 0; i < 5; i++) io_txn(T_IN, 7'h03, NAK, 4'd0, 0);
      io_txn(T_IN, 7'h03, ACK, 4'd8, 0);
      for (int i = 0; i < 3; i++) io_txn(T_IN, 7'h03, TMO, 4'd0, 0);
      expect_cpl(C_ERR, 16'd8);
      send_req(7'h03, SU_DEV);
      wait_cpl(300);

      // SETUP NAKs count as timeouts
      setup_txn(7'h33, SU_ADDR, NAK);
      setup_txn(7'h33, SU_ADDR, TMO);
      setup_txn(7'h33, SU_ADDR, NAK);
      expect_cpl(C_ERR, 16'd0);
      send_req(7'h33, SU_ADDR);
      wait_cpl(200);

      // two timeouts per stage, each stage's ACK clears the retry count
      setup_txn(7'h2a, SU_DEV, TMO);
      setup_txn(7'h2a, SU_DEV, TMO);
      setup_txn(7'h2a, SU_DEV, ACK);
      io_txn(T_IN, 7'h2a, TMO, 4'd0, 0);
      io_txn(T_IN, 7'h2a, TMO, 4'd0, 0);
      io_txn(T_IN, 7'h2a, ACK, 4'd2, 0);
      io_txn(T_OUT, 7'h2a, TMO, 4'd0, 0);
      io_txn(T_OUT, 7'h2a, TMO, 4'd0, 0);
      io_txn(T_OUT, 7'h2a, ACK, 4'd0, 0);
      expect_cpl(C_OK, 16'd2);
      send_req(7'h2a, SU_DEV);
      wait_cpl(300);

      // host-to-device with data: no transactions at all
      base = txn_seen;
      expect_cpl(C_UNSUP, 16'd0);
      send_req(7'h44, SU_H2D);
      wait_cpl(100);
      check("unsup_no_txn", txn_seen - base, 0);

      // reset while waiting for the data-stage result
      base = txn_seen;
      setup_txn(7'h09, SU_DEV, ACK);
      io_txn(T_IN, 7'h09, ACK, 4'd0, 1);
      send_req(7'h09, SU_DEV);
      n = 0;
      while (txn_seen < base + 2 && n < 100) begin @(negedge i_clk); n++; end
      check("abort_reach_data", txn_seen - base, 2);
      @(negedge i_clk);
      i_rstn = 1'b0;
      repeat (2) @(negedge i_clk);
      check("abort_outputs", {o_txnValid, o_cplValid, o_reqReady}, 3'b000);
      i_rstn = 1'b1;
      repeat (5) @(negedge i_clk);
      check("abort_quiet", {o_txnValid, o_cplValid, o_reqReady}, 3'b001);

      setup_txn(7'h11, SU_ADDR, ACK);
      io_txn(T_IN, 7'h11, ACK, 4'd0, 0);
      expect_cpl(C_OK, 16'd0);
      send_req(7'h11, SU_ADDR);
      wait_cpl(200);

      // 8192 full packets against wLength 0xffff: reported count saturates
      setup_txn(7'h7f, SU_CFG, ACK);
      for (int i = 0; i < 8192; i++) io_txn(T_IN, 7'h7f, ACK, 4'd8, 0);
      io_txn(T_OUT, 7'h7f, ACK, 4'd0, 0);
      expect_cpl(C_OK, 16'hffff);
      send_req(7'h7f, SU_CFG);
      wait_cpl(40000);

      repeat (5) @(negedge i_clk);
      check("txn_queue_drained", exp_txn.size(), 0);
      check("rslt_queue_drained", rsp_q.size(), 0);
      check("cpl_queue_drained", exp_cpl.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
